// File: rtl/weight_glb_stream.sv
// Weight GLB streamer: fetches weight tiles from memory into one FIFO per array
// column, then drains them into the systolic array with a one-step-per-column skew.
module weight_glb_stream #(
  parameter int PE_SIZE        = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [MEM_ADDR_WIDTH-1:0]       cfg_base_addr,
  input  logic [$clog2(FIFO_DEPTH):0]     cfg_rows,
  input  logic [7:0]                      cfg_tiles,
  output logic                            mem_ce,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
  input  logic [PE_SIZE*DATA_WIDTH-1:0]   mem_q,
  input  logic                            sa_ready,
  output logic [PE_SIZE*DATA_WIDTH-1:0]   weight_o,
  output logic [PE_SIZE-1:0]              weight_en_col_o,
  output logic                            busy,
  output logic                            tile_done,
  output logic                            done
);

  localparam int RW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KW = $clog2(FIFO_DEPTH + PE_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]             rows_q;
  logic [RW-1:0]             rows_clamped;
  logic [RW-1:0]             rd_cnt_q;
  logic [RW-1:0]             push_cnt_q;
  logic [7:0]                tiles_q;
  logic [7:0]                tile_q;
  logic                      push_vld_q;
  logic [KW-1:0]             k_q;
  logic [KW-1:0]             k_last;
  logic [PW-1:0]             wr_ptr_q;
  logic [PW-1:0]             rd_ptr_q [PE_SIZE];
  logic [DATA_WIDTH-1:0]     fifo_mem [PE_SIZE][FIFO_DEPTH];
  logic                      load_last_push;
  logic                      drain_step;
  logic                      last_tile;
  logic [PE_SIZE-1:0]        pop;

  assign rows_clamped   = (cfg_rows > RW'(FIFO_DEPTH)) ? RW'(FIFO_DEPTH) : cfg_rows;
  assign load_last_push = push_vld_q && (push_cnt_q == rows_q - RW'(1));
  assign k_last         = KW'(rows_q) + KW'(PE_SIZE) - KW'(2);
  // The tile_done cycle is a pause: no pops, the FSM moves on next edge.
  assign drain_step     = (state_q == DRAIN) && sa_ready && !tile_done;
  assign last_tile      = (tile_q == tiles_q - 8'd1);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign mem_ce   = (state_q == LOAD) && (rd_cnt_q != rows_q);
  assign mem_addr = mem_ce ? addr_q : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((rows_clamped == '0) || (cfg_tiles == 8'd0)) state_d = FIN;
          else                                             state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_last_push) state_d = DRAIN;
      end
      DRAIN: begin
        if (tile_done) state_d = last_tile ? FIN : LOAD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column c pops at drain steps c .. c+R-1, giving the diagonal wavefront.
  always_comb begin
    pop = '0;
    for (int c = 0; c < PE_SIZE; c++) begin
      if (drain_step && (int'(k_q) >= c) && (int'(k_q) < c + int'(rows_q)))
        pop[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rows_q     <= '0;
      tiles_q    <= '0;
      tile_q     <= '0;
      rd_cnt_q   <= '0;
      push_cnt_q <= '0;
      push_vld_q <= 1'b0;
      k_q        <= '0;
      tile_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_vld_q <= mem_ce;
      tile_done  <= drain_step && (k_q == k_last);
      if ((state_q == IDLE) && start) begin
        addr_q     <= cfg_base_addr;
        rows_q     <= rows_clamped;
        tiles_q    <= cfg_tiles;
        tile_q     <= '0;
        rd_cnt_q   <= '0;
        push_cnt_q <= '0;
        k_q        <= '0;
      end
      // Tiles are contiguous in memory, so the address just keeps counting.
      if (mem_ce) begin
        addr_q   <= addr_q + MEM_ADDR_WIDTH'(1);
        rd_cnt_q <= rd_cnt_q + RW'(1);
      end
      if (push_vld_q) push_cnt_q <= push_cnt_q + RW'(1);
      if (drain_step) k_q <= k_q + KW'(1);
      if (tile_done) begin
        k_q        <= '0;
        rd_cnt_q   <= '0;
        push_cnt_q <= '0;
        tile_q     <= tile_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      weight_o        <= '0;
      weight_en_col_o <= '0;
      for (int c = 0; c < PE_SIZE; c++) rd_ptr_q[c] <= '0;
    end else begin
      if (push_vld_q) wr_ptr_q <= wr_ptr_q + PW'(1);
      weight_en_col_o <= pop;
      for (int c = 0; c < PE_SIZE; c++) begin
        if (pop[c]) begin
          weight_o[c*DATA_WIDTH +: DATA_WIDTH] <= fifo_mem[c][rd_ptr_q[c]];
          rd_ptr_q[c]                          <= rd_ptr_q[c] + PW'(1);
        end
      end
    end
  end

  // Storage needs no reset; pushes and pops never share a cycle.
  always_ff @(posedge clk) begin
    if (push_vld_q) begin
      for (int c = 0; c < PE_SIZE; c++)
        fifo_mem[c][wr_ptr_q] <= mem_q[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_weight_glb_stream.sv
// Self-checking bench for weight_glb_stream: per-job expected schedule is derived
// from the streaming rules, then compared against the DUT on every cycle.
module tb_weight_glb_stream;

  localparam int PE   = 4;
  localparam int DW   = 8;
  localparam int FD   = 8;
  localparam int AW   = 10;
  localparam int MAXC = 600;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     cfg_base_addr;
  logic [3:0]        cfg_rows;
  logic [7:0]        cfg_tiles;
  logic              mem_ce;
  logic [AW-1:0]     mem_addr;
  logic [PE*DW-1:0]  mem_q = '0;
  logic              sa_ready;
  logic [PE*DW-1:0]  weight_o;
  logic [PE-1:0]     weight_en_col_o;
  logic              busy;
  logic              tile_done;
  logic              done;

  weight_glb_stream #(
    .PE_SIZE(PE), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MEM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles), .mem_ce(mem_ce), .mem_addr(mem_addr),
    .mem_q(mem_q), .sa_ready(sa_ready), .weight_o(weight_o),
    .weight_en_col_o(weight_en_col_o), .busy(busy), .tile_done(tile_done), .done(done)
  );

  always #5 clk = ~clk;

  logic [PE*DW-1:0] mem_words [1 << AW];

  // Memory returns the word one cycle after the read; garbage otherwise.
  always @(posedge clk) mem_q <= mem_ce ? mem_words[mem_addr] : 32'($urandom);

  int tests = 0;
  int failures = 0;
  int job_id = 0;
  int cur_off = 0;
  int ce_count, td_count, done_count;
  int done_off;
  int td_list[$];
  logic [AW-1:0] addr_list[$];
  logic [PE*DW-1:0] model_w = '0;

  bit               rdy      [MAXC];
  logic             exp_ce   [MAXC];
  logic [AW-1:0]    exp_addr [MAXC];
  logic [PE-1:0]    exp_en   [MAXC];
  logic [PE*DW-1:0] exp_data [MAXC];
  logic             exp_td   [MAXC];
  logic             exp_done [MAXC];
  logic             exp_busy [MAXC];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s job%0d off%0d: got 0x%0h, expected 0x%0h", name, job_id, cur_off, act, exp);
    end
  endtask

  // Offsets are cycles counted from the start pulse (offset 0).
  task automatic buildSchedule(input logic [AW-1:0] base, input int rows_raw, input int tiles);
    int r, cur, s, last_step, t_load, td;
    logic [AW-1:0] a;
    logic [PE*DW-1:0] word;
    for (int i = 0; i < MAXC; i++) begin
      exp_ce[i] = 0; exp_addr[i] = '0; exp_en[i] = '0; exp_data[i] = '0;
      exp_td[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
    end
    addr_list.delete();
    td_list.delete();
    r = (rows_raw > FD) ? FD : rows_raw;
    if (r == 0 || tiles == 0) begin
      done_off = 1;
      exp_busy[1] = 1;
      exp_done[1] = 1;
      return;
    end
    t_load = 1;
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i < r; i++) begin
        a = AW'(int'(base) + t * r + i);
        exp_ce[t_load + i]   = 1;
        exp_addr[t_load + i] = a;
        addr_list.push_back(a);
      end
      cur = t_load + r + 1;
      s = 0;
      last_step = cur;
      while (s <= r + PE - 2 && cur < MAXC - 4) begin
        if (rdy[cur]) begin
          for (int c = 0; c < PE; c++) begin
            if (s >= c && s - c < r) begin
              a = AW'(int'(base) + t * r + s - c);
              word = mem_words[a];
              exp_en[cur + 1][c] = 1'b1;
              exp_data[cur + 1][c*DW +: DW] = word[c*DW +: DW];
            end
          end
          last_step = cur;
          s++;
        end
        cur++;
      end
      td = last_step + 1;
      exp_td[td] = 1;
      td_list.push_back(td);
      t_load = td + 1;
    end
    done_off = t_load;
    exp_done[done_off] = 1;
    for (int i = 1; i <= done_off; i++) exp_busy[i] = 1;
  endtask

  task automatic checkOutput(input int off);
    cur_off = off;
    checkVal("mem_ce", 64'(mem_ce), 64'(exp_ce[off]));
    if (exp_ce[off]) checkVal("mem_addr", 64'(mem_addr), 64'(exp_addr[off]));
    checkVal("weight_en", 64'(weight_en_col_o), 64'(exp_en[off]));
    for (int c = 0; c < PE; c++)
      if (exp_en[off][c]) model_w[c*DW +: DW] = exp_data[off][c*DW +: DW];
    checkVal("weight_o", 64'(weight_o), 64'(model_w));
    checkVal("tile_done", 64'(tile_done), 64'(exp_td[off]));
    checkVal("done", 64'(done), 64'(exp_done[off]));
    checkVal("busy", 64'(busy), 64'(exp_busy[off]));
    if (mem_ce === 1'b1) ce_count++;
    if (tile_done === 1'b1) td_count++;
    if (done === 1'b1) done_count++;
  endtask

  task automatic checkReset();
    cur_off = -1;
    model_w = '0;
    checkVal("rst_mem_ce", 64'(mem_ce), 64'(0));
    checkVal("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkVal("rst_weight_o", 64'(weight_o), 64'(0));
    checkVal("rst_weight_en", 64'(weight_en_col_o), 64'(0));
    checkVal("rst_busy", 64'(busy), 64'(0));
    checkVal("rst_tile_done", 64'(tile_done), 64'(0));
    checkVal("rst_done", 64'(done), 64'(0));
  endtask

  // extra_at = -2 picks a random busy cycle for an ignored second start.
  task automatic applyStimulus(input logic [AW-1:0] base, input int rows, input int tiles,
                               input bit rand_rdy, input int stall_at, input int extra_at,
                               input int abort_at);
    int last;
    int extra;
    job_id++;
    ce_count = 0; td_count = 0; done_count = 0;
    for (int i = 0; i < MAXC; i++)
      rdy[i] = (i >= 200) ? 1'b1 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (stall_at >= 0) begin
      rdy[stall_at] = 1'b0;
      rdy[stall_at + 1] = 1'b0;
    end
    buildSchedule(base, rows, tiles);
    extra = (extra_at == -2) ? int'($urandom_range(1, done_off)) : extra_at;
    last = (abort_at >= 0) ? abort_at : done_off + 1;
    for (int i = 0; i <= last; i++) begin
      rst   = (i == abort_at);
      start = (i == 0) || (i == extra) || (i == abort_at);
      if (i == 0) begin
        cfg_base_addr = base;
        cfg_rows      = 4'(rows);
        cfg_tiles     = 8'(tiles);
      end else begin
        cfg_base_addr = AW'($urandom);
        cfg_rows      = 4'($urandom);
        cfg_tiles     = 8'($urandom_range(0, 3));
      end
      sa_ready = rdy[i];
      @(negedge clk);
      checkOutput(i);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) begin
      @(negedge clk);
      checkReset();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [AW-1:0] exp24 [4];
    logic [AW-1:0] rb;
    int rr, rt, reff;

    for (int i = 0; i < (1 << AW); i++) mem_words[i] = $urandom;
    rst = 1'b1; start = 1'b0; sa_ready = 1'b0;
    cfg_base_addr = '0; cfg_rows = '0; cfg_tiles = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single tile, full ready
    applyStimulus(10'h010, 3, 1, 1'b0, -1, -1, -1);
    checkVal("model_td_off", 64'(td_list[0]), 64'(11));
    checkVal("model_done_off", 64'(done_off), 64'(12));
    checkVal("model_en9", 64'(exp_en[9]), 64'(4'b1110));
    checkVal("model_addr2", 64'(addr_list[2]), 64'(10'h012));
    checkVal("ce_count", 64'(ce_count), 64'(3));
    checkVal("td_count", 64'(td_count), 64'(1));
    checkVal("done_count", 64'(done_count), 64'(1));

    // Two-cycle stall mid-drain
    applyStimulus(10'h010, 3, 1, 1'b0, 7, -1, -1);
    checkVal("model_stall_en", 64'(exp_en[9]), 64'(0));
    checkVal("model_stall_td", 64'(td_list[0]), 64'(13));
    checkVal("td_count", 64'(td_count), 64'(1));

    // Two tiles wrapping the address space
    applyStimulus(10'h3FE, 2, 2, 1'b0, -1, -1, -1);
    exp24 = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    checkVal("model_addr_n", 64'(addr_list.size()), 64'(4));
    for (int i = 0; i < 4 && i < addr_list.size(); i++)
      checkVal("model_addr_wrap", 64'(addr_list[i]), 64'(exp24[i]));
    checkVal("ce_count", 64'(ce_count), 64'(4));
    checkVal("td_count", 64'(td_count), 64'(2));
    checkVal("done_count", 64'(done_count), 64'(1));

    // Degenerate and clamped jobs
    applyStimulus(10'h123, 0, 2, 1'b0, -1, -1, -1);
    checkVal("model_done_off0", 64'(done_off), 64'(1));
    checkVal("ce_count_rows0", 64'(ce_count), 64'(0));
    applyStimulus(10'h050, 3, 0, 1'b0, -1, -1, -1);
    checkVal("ce_count_tiles0", 64'(ce_count), 64'(0));
    applyStimulus(10'h200, 12, 2, 1'b1, -1, -1, -1);
    checkVal("ce_count_clamp", 64'(ce_count), 64'(16));
    checkVal("td_count_clamp", 64'(td_count), 64'(2));

    // Ignored start in drain, then reset mid-drain, then a clean rerun
    applyStimulus(10'h010, 3, 1, 1'b0, -1, 6, 8);
    applyStimulus(10'h010, 3, 1, 1'b0, -1, -1, -1);
    checkVal("ce_count_rerun", 64'(ce_count), 64'(3));
    checkVal("done_count_rerun", 64'(done_count), 64'(1));

    // Randomized jobs with random back-pressure
    for (int j = 0; j < 16; j++) begin
      rb = AW'($urandom);
      rr = $urandom_range(0, 12);
      rt = $urandom_range(0, 3);
      reff = (rr > FD) ? FD : rr;
      applyStimulus(rb, rr, rt, 1'b1, -1, -2, -1);
      checkVal("rand_ce_count", 64'(ce_count), 64'(reff * rt));
      checkVal("rand_td_count", 64'(td_count), 64'((reff == 0) ? 0 : rt));
      checkVal("rand_done_count", 64'(done_count), 64'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/weight_glb_stream.md
WEIGHT_GLB_STREAM -- requirements
Module: weight_glb_stream

Interface
REQ-001 SHALL have parameter PE_SIZE, default 16: systolic array columns, one column FIFO per column.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per weight element.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entries per column FIFO, power of two.
REQ-004 SHALL have parameter MEM_ADDR_WIDTH, default 10: weight memory address width.
REQ-005 SHALL have ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that launches a job
- cfg_base_addr  in  MEM_ADDR_WIDTH  first memory word of the job
- cfg_rows  in  $clog2(FIFO_DEPTH)+1  weight rows per tile
- cfg_tiles  in  8  tiles per job
- mem_ce  out  1  memory read enable
- mem_addr  out  MEM_ADDR_WIDTH  memory read address
- mem_q  in  PE_SIZE*DATA_WIDTH  read data, valid one cycle after mem_ce; slice c feeds column c
- sa_ready  in  1  array accepts data this cycle
- weight_o  out  PE_SIZE*DATA_WIDTH  registered column data, slice c = column c
- weight_en_col_o  out  PE_SIZE  per-column valid
- busy  out  1  job in progress
- tile_done  out  1  one-cycle pulse per drained tile
- done  out  1  one-cycle pulse at job end

Function
REQ-006 SHALL implement FSM IDLE -> LOAD -> DRAIN -> (LOAD if tiles remain, else FIN) -> IDLE.
REQ-007 SHALL, in IDLE, latch all cfg_* on start and enter LOAD next cycle; start while busy SHALL be ignored.
REQ-008 SHALL clamp latched cfg_rows to FIFO_DEPTH when it exceeds FIFO_DEPTH.
REQ-009 SHALL, if latched cfg_rows=0 or cfg_tiles=0, go IDLE -> FIN with no memory reads; done pulses one cycle after start.
REQ-010 SHALL, in LOAD, assert mem_ce for exactly R consecutive cycles (R = clamped rows), addresses base+t*R+0 .. base+t*R+R-1 for tile t, modulo 2^MEM_ADDR_WIDTH.
REQ-011 SHALL push mem_q slice c into column FIFO c in the cycle after each mem_ce; LOAD ends after the R-th push, then DRAIN.
REQ-012 SHALL hold a drain step counter k, 0 .. R+PE_SIZE-2, advancing only in cycles where sa_ready=1.
REQ-013 SHALL, at step k with sa_ready=1, pop column c iff 0 <= k-c < R (diagonal skew, column c lags column 0 by c steps).
REQ-014 SHALL register popped data to weight_o slice c and set weight_en_col_o[c]=1 in the following cycle; otherwise weight_en_col_o[c]=0 and weight_o slice c holds.
REQ-015 SHALL, when sa_ready=0, freeze k, FIFOs and pointers; no data lost or duplicated.
REQ-016 SHALL pulse tile_done in the cycle the last column's final entry appears on weight_o.
REQ-017 SHALL, after tile_done for tile t < cfg_tiles-1, re-enter LOAD next cycle; after the last tile, enter FIN, pulse done one cycle, return IDLE.
REQ-018 SHALL assert busy in every state except IDLE; mem_ce is never asserted in DRAIN.
REQ-019 SHALL never overflow/underflow FIFOs; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-020 SHALL, with rst=1 at a clock edge, go IDLE, clear FIFO pointers and counters, drive mem_ce, mem_addr, weight_o, weight_en_col_o, busy, tile_done, done to 0.
REQ-021 SHALL honour rst mid-job (any state), abandoning the job; rst has priority over start in the same cycle.

Verification (PE_SIZE=4, DATA_WIDTH=8, FIFO_DEPTH=8, MEM_ADDR_WIDTH=10)
REQ-022 Single tile: base=0x010, rows=3, tiles=1, sa_ready=1 -> mem_addr 0x010,0x011,0x012 on 3 consecutive cycles; column c valid on 3 cycles starting c cycles after column 0; tile_done and done pulse once each.
REQ-023 Back-pressure: as REQ-022, sa_ready=0 for 2 cycles mid-drain -> weight_en_col_o=0 and weight_o held during stall; output sequence per column identical to REQ-022.
REQ-024 Multi-tile wrap: base=0x3FE, rows=2, tiles=2 -> addresses 0x3FE,0x3FF,0x000,0x001; two tile_done pulses, one done.
REQ-025 Degenerate/clamp: rows=0 -> no mem_ce, done one cycle after start; rows=12 -> exactly 8 reads per tile.
REQ-026 Reset mid-DRAIN plus start during busy: extra start ignored; rst mid-drain -> all outputs 0 next cycle, new job afterwards runs as REQ-022.
